efuse_access_arb: RTL
=====================

// Module: efuse_access_arb
// PURPOSE
//  Arbitrates the single EFUSE macro port between three requesters: PMU autoload (0), SW read (1), SW write (2).
//  Grants one owner at a time and muxes its PGMEN/RDEN/AEN/ADDR onto the macro through registers.
//  Inserts guard cycles between owners and enforces a per-grant timeout.
//  Sits between the efuse_read/efuse_write sequencers and the macro, replacing point-to-point muxing.
// PARAMETERS
//  GUARD_CYC  4   idle cycles (all macro strobes 0) after every release, range 1..15
//  TOUT_W     16  width of the grant-timeout limit/counter
// PORTS
//  clk           in   1         system clock
//  rst_n         in   1         async active-low reset
//  req_i         in   3         level requests [0]=autoload [1]=read [2]=write, held until done
//  done_i        in   3         1-cycle done pulse from each requester
//  pgmen_i       in   3         per-requester PGMEN
//  rden_i        in   3         per-requester RDEN
//  aen_i         in   3         per-requester AEN
//  addr_i        in   24        per-requester ADDR, [8k+7:8k] = requester k
//  rg_tout       in   TOUT_W    grant timeout in clk cycles, 0 = disabled
//  rg_tout_clr   in   1         pulse, clears tout_err_o
//  gnt_o         out  3         one-hot grant, registered
//  owner_o       out  2         current owner encoding, 3 = none
//  busy_o        out  1         1 in GRANT or GUARD
//  tout_err_o    out  1         sticky timeout flag
//  tout_owner_o  out  2         owner that timed out last
//  efuse_pgmen_o out  1         to macro, registered
//  efuse_rden_o  out  1         to macro, registered
//  efuse_aen_o   out  1         to macro, registered
//  efuse_addr_o  out  8         to macro, registered
// BEHAVIOUR
//  Reset: gnt_o=0, owner_o=3, busy_o=0, tout_err_o=0, tout_owner_o=0, all efuse_*_o=0, last_rw=WRITE.
//  FSM:
//   IDLE  -> GRANT when any req_i is set. Winner is registered, so gnt_o rises 1 cycle after req_i is sampled.
//   GRANT -> GUARD on done_i[owner], on req_i[owner] deasserting (abort, no error), or on timeout.
//   GUARD -> IDLE after GUARD_CYC cycles. gnt_o=0 and all macro outputs are 0 throughout GUARD.
//  Priority: autoload first. When read and write are both pending, they alternate: the one not equal to last_rw wins.
//   last_rw updates on each read/write grant.
//  No preemption. A higher-priority request waits for release plus guard.
//  Mux: in GRANT, efuse_*_o <= owner's inputs (1-cycle latency). Non-owner inputs are ignored.
//  Safety: efuse_pgmen_o is forced 0 unless the owner is write (2).
//  Timeout: counter clears on GRANT entry and increments each GRANT cycle.
//   When rg_tout!=0 and count==rg_tout-1: release, tout_err_o<=1, tout_owner_o<=owner.
//   The counter saturates and never wraps.
//  Simultaneous events:
//   done_i and timeout in the same cycle: done wins, no error.
//   rg_tout_clr and a new timeout in the same cycle: set wins.
//   done_i from a non-owner: ignored.
//  Reset mid-operation: all outputs drop asynchronously (PGMEN low immediately) and the FSM returns to IDLE.
//   Requesters must restart.
// STRUCTURE
//  efuse_pkg: typedef enum logic[1:0] {OWN_AL, OWN_RD, OWN_WR, OWN_NONE} efuse_owner_e;
//   typedef enum logic[1:0] {ARB_IDLE, ARB_GRANT, ARB_GUARD} efuse_arb_st_e.
//  Sub-module efuse_arb_tmr: a shared down/up counter serving both guard countdown and grant timeout.
//   Inputs: load, mode, limit. Output: expire.
// TESTING
//  T1: after reset, req_i=001 -> gnt_o=001 next cycle; efuse_aen_o follows aen_i[0] one cycle later; busy_o=1.
//  T2: req_i=110 from IDLE -> read granted first (last_rw=WRITE at reset).
//   Read done -> exactly 4 idle cycles with macro outputs 0 -> gnt_o=100.
//  T3: autoload req during write grant -> no preemption.
//   After write done+guard, autoload is granted ahead of a pending read.
//  T4: rg_tout=100, owner=read never sends done -> gnt_o drops at grant cycle 100, tout_err_o=1, tout_owner_o=1.
//   rg_tout_clr -> tout_err_o=0.
//  T5: read owner drives pgmen_i[1]=1 with rden_i[1]=1 -> efuse_pgmen_o stays 0, efuse_rden_o=1.
//  T6: rst_n low mid write grant with pgmen_i[2]=1 -> efuse_pgmen_o=0 without a clock edge.
//   After release, req_i=100 is granted again from IDLE.

Source files
------------

// File: rtl/efuse_access_arb_pkg.sv
// Shared types and helpers for the EFUSE macro-port arbiter.
// Requester indices double as owner codes so a grant can be turned into a one-hot vector directly.
package efuse_pkg;

    typedef enum logic [1:0] {OWN_AL, OWN_RD, OWN_WR, OWN_NONE} efuse_owner_e;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GUARD} efuse_arb_st_e;

    function automatic logic [2:0] owner_onehot(input efuse_owner_e owner);
        case (owner)
            OWN_AL:  return 3'b001;
            OWN_RD:  return 3'b010;
            OWN_WR:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/efuse_access_arb_if.sv
// Bundle of requester-side inputs, status outputs and macro strobes of the EFUSE arbiter.
// The arbiter sits on the slave modport; whoever drives the requests uses the master modport.
interface efuse_access_arb_if #(
    parameter int TOUT_W = 16
);
    logic [2:0]        req_i;
    logic [2:0]        done_i;
    logic [2:0]        pgmen_i;
    logic [2:0]        rden_i;
    logic [2:0]        aen_i;
    logic [23:0]       addr_i;
    logic [TOUT_W-1:0] rg_tout;
    logic              rg_tout_clr;
    logic [2:0]        gnt_o;
    logic [1:0]        owner_o;
    logic              busy_o;
    logic              tout_err_o;
    logic [1:0]        tout_owner_o;
    logic              efuse_pgmen_o;
    logic              efuse_rden_o;
    logic              efuse_aen_o;
    logic [7:0]        efuse_addr_o;

    modport slave (
        input  req_i, done_i, pgmen_i, rden_i, aen_i, addr_i, rg_tout, rg_tout_clr,
        output gnt_o, owner_o, busy_o, tout_err_o, tout_owner_o,
        output efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o
    );

    modport master (
        output req_i, done_i, pgmen_i, rden_i, aen_i, addr_i, rg_tout, rg_tout_clr,
        input  gnt_o, owner_o, busy_o, tout_err_o, tout_owner_o,
        input  efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o
    );

endinterface

// File: rtl/efuse_access_arb_tmr.sv
// Single counter shared by the grant timeout (counts up, saturating) and the guard gap (counts down to 0).
// The counting mode is captured on load so the expire output never depends on the same-cycle load request.
module efuse_arb_tmr #(
    parameter int             W         = 16,
    parameter logic [W-1:0]   DOWN_INIT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_mode,
    input  logic [W-1:0] i_limit,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;
    logic         r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_cnt  <= i_mode ? DOWN_INIT : '0;
        end else if (r_mode) begin
            if (r_cnt != '0)
                r_cnt <= r_cnt - W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Up mode: a zero limit disables the timeout entirely.
    assign o_expire = r_mode ? (r_cnt == '0)
                             : ((i_limit != '0) && (r_cnt == i_limit - W'(1)));

endmodule

// File: rtl/efuse_access_arb.sv
// Grants the single EFUSE macro port to autoload, SW read or SW write, one at a time, with a
// registered strobe mux, a guard gap after each release and an optional per-grant timeout.
module efuse_access_arb
    import efuse_pkg::*;
#(
    parameter int GUARD_CYC = 4,
    parameter int TOUT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    efuse_access_arb_if.slave   bus
);

    efuse_arb_st_e r_state;
    efuse_arb_st_e w_next;
    efuse_owner_e  r_owner;
    efuse_owner_e  r_last_rw;
    efuse_owner_e  r_tout_owner;
    efuse_owner_e  w_winner;
    logic [2:0]    r_gnt;
    logic          r_tout_err;
    logic          r_pgmen;
    logic          r_rden;
    logic          r_aen;
    logic [7:0]    r_addr;

    logic          w_own_req;
    logic          w_own_done;
    logic          w_own_pgmen;
    logic          w_own_rden;
    logic          w_own_aen;
    logic [7:0]    w_own_addr;
    logic          w_expire;
    logic          w_tmr_load;
    logic          w_tmr_mode;
    logic          w_release;
    logic          w_tout_hit;

    always_comb begin
        w_own_req   = 1'b0;
        w_own_done  = 1'b0;
        w_own_pgmen = 1'b0;
        w_own_rden  = 1'b0;
        w_own_aen   = 1'b0;
        w_own_addr  = 8'h00;
        case (r_owner)
            OWN_AL: begin
                w_own_req   = bus.req_i[0];
                w_own_done  = bus.done_i[0];
                w_own_pgmen = bus.pgmen_i[0];
                w_own_rden  = bus.rden_i[0];
                w_own_aen   = bus.aen_i[0];
                w_own_addr  = bus.addr_i[7:0];
            end
            OWN_RD: begin
                w_own_req   = bus.req_i[1];
                w_own_done  = bus.done_i[1];
                w_own_pgmen = bus.pgmen_i[1];
                w_own_rden  = bus.rden_i[1];
                w_own_aen   = bus.aen_i[1];
                w_own_addr  = bus.addr_i[15:8];
            end
            OWN_WR: begin
                w_own_req   = bus.req_i[2];
                w_own_done  = bus.done_i[2];
                w_own_pgmen = bus.pgmen_i[2];
                w_own_rden  = bus.rden_i[2];
                w_own_aen   = bus.aen_i[2];
                w_own_addr  = bus.addr_i[23:16];
            end
            default: ;
        endcase
    end

    // Autoload always first; read and write take turns when both are waiting.
    always_comb begin
        w_winner = OWN_NONE;
        if (bus.req_i[0])
            w_winner = OWN_AL;
        else if (bus.req_i[1] && bus.req_i[2])
            w_winner = (r_last_rw == OWN_RD) ? OWN_WR : OWN_RD;
        else if (bus.req_i[1])
            w_winner = OWN_RD;
        else if (bus.req_i[2])
            w_winner = OWN_WR;
    end

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_mode = 1'b0;
        w_release  = 1'b0;
        w_tout_hit = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_winner != OWN_NONE) begin
                    w_next     = ARB_GRANT;
                    w_tmr_load = 1'b1;
                end
            end
            ARB_GRANT: begin
                w_release  = w_own_done || !w_own_req || w_expire;
                w_tout_hit = w_expire && !w_own_done;
                if (w_release) begin
                    w_next     = ARB_GUARD;
                    w_tmr_load = 1'b1;
                    w_tmr_mode = 1'b1;
                end
            end
            ARB_GUARD: begin
                if (w_expire)
                    w_next = ARB_IDLE;
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ARB_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_NONE;
            r_gnt     <= 3'b000;
            r_last_rw <= OWN_WR;
        end else if (r_state == ARB_IDLE && w_next == ARB_GRANT) begin
            r_owner <= w_winner;
            r_gnt   <= owner_onehot(w_winner);
            if (w_winner != OWN_AL)
                r_last_rw <= w_winner;
        end else if (w_release) begin
            r_owner <= OWN_NONE;
            r_gnt   <= 3'b000;
        end
    end

    // Strobes are zero on the grant edge, the release edge and throughout guard/idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pgmen <= 1'b0;
            r_rden  <= 1'b0;
            r_aen   <= 1'b0;
            r_addr  <= 8'h00;
        end else if (r_state == ARB_GRANT && !w_release) begin
            r_pgmen <= (r_owner == OWN_WR) && w_own_pgmen;
            r_rden  <= w_own_rden;
            r_aen   <= w_own_aen;
            r_addr  <= w_own_addr;
        end else begin
            r_pgmen <= 1'b0;
            r_rden  <= 1'b0;
            r_aen   <= 1'b0;
            r_addr  <= 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tout_err   <= 1'b0;
            r_tout_owner <= OWN_AL;
        end else if (w_tout_hit) begin
            r_tout_err   <= 1'b1;
            r_tout_owner <= r_owner;
        end else if (bus.rg_tout_clr) begin
            r_tout_err <= 1'b0;
        end
    end

    efuse_arb_tmr #(
        .W         (TOUT_W),
        .DOWN_INIT (TOUT_W'(GUARD_CYC - 1))
    ) u_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_mode   (w_tmr_mode),
        .i_limit  (bus.rg_tout),
        .o_expire (w_expire)
    );

    assign bus.gnt_o         = r_gnt;
    assign bus.owner_o       = r_owner;
    assign bus.busy_o        = (r_state != ARB_IDLE);
    assign bus.tout_err_o    = r_tout_err;
    assign bus.tout_owner_o  = r_tout_owner;
    assign bus.efuse_pgmen_o = r_pgmen;
    assign bus.efuse_rden_o  = r_rden;
    assign bus.efuse_aen_o   = r_aen;
    assign bus.efuse_addr_o  = r_addr;

endmodule
